phase_discriminator_decim: RTL and testbench

FM/phase discriminator that consumes the 16-bit phase stream produced by the complex-to-magnitude/phase split stage. It computes the wrapped sample-to-sample phase difference (instantaneous frequency), integrates it over a programmable decimation group, then rounds, shifts and saturates the sum to 16 bits. It sits between the phase output of the split stage and the phase-side CHDR framer. Packet boundaries are preserved: an input `tlast` always closes the current group.

---
 rtl/gmrr_phase_pkg.sv | 7 +
 rtl/phase_round_sat.sv | 35 +++
 rtl/phase_discriminator_decim.sv | 98 +++++++++
 tb/tb_phase_discriminator_decim.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gmrr_phase_pkg.sv
// Shared phase-path constants: sample width, shift limit and binary-angle values.
package gmrr_phase_pkg;
    localparam int unsigned PHASE_W   = 16;
    localparam int unsigned SHIFT_MAX = 8;
    localparam logic [15:0] ANG_PI      = 16'h8000;
    localparam logic [15:0] ANG_HALF_PI = 16'h4000;
endpackage

// File: rtl/phase_round_sat.sv
// Round-half-up, arithmetic right shift and saturation of a signed sum to PHASE_W bits.
module phase_round_sat
    import gmrr_phase_pkg::PHASE_W;
#(
    parameter int unsigned IN_W      = 24,
    parameter int unsigned SHIFT_MAX = 8
) (
    input  logic [IN_W-1:0]    sum,
    input  logic [3:0]         shift,
    output logic [PHASE_W-1:0] sat_c
);
    localparam int unsigned EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (PHASE_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [3:0]              sh;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] shifted;

    // One guard bit keeps the rounding add from overflowing the sum.
    always_comb begin
        sh      = (shift > 4'(SHIFT_MAX)) ? 4'(SHIFT_MAX) : shift;
        rnd     = (sh == 4'd0) ? '0 : (EXT_W'(1) << (sh - 4'd1));
        ext     = $signed({sum[IN_W-1], sum}) + rnd;
        shifted = ext >>> sh;
        if (shifted > SAT_MAX) begin
            sat_c = SAT_MAX[PHASE_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_c = SAT_MIN[PHASE_W-1:0];
        end else begin
            sat_c = shifted[PHASE_W-1:0];
        end
    end
endmodule

// File: rtl/phase_discriminator_decim.sv
// FM discriminator: wrapped phase difference, integrated over a decimation group,
// then rounded/shifted/saturated into a 16-bit frequency stream.
module phase_discriminator_decim
    import gmrr_phase_pkg::*;
#(
    parameter int unsigned DECIM_W = 8,
    parameter int unsigned ACC_W   = 24
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               clear,
    input  logic [DECIM_W-1:0] decim,
    input  logic [3:0]         shift,
    input  logic [15:0]        i_tdata,
    input  logic               i_tlast,
    input  logic               i_tvalid,
    output logic               i_tready,
    output logic [15:0]        o_tdata,
    output logic               o_tlast,
    output logic               o_tvalid,
    input  logic               o_tready
);
    logic [PHASE_W-1:0] prev;
    logic               prev_valid;
    logic [ACC_W-1:0]   acc;
    logic [DECIM_W-1:0] cnt;
    logic [DECIM_W-1:0] d_lat;

    logic [PHASE_W-1:0] diff;
    logic [ACC_W-1:0]   diff_ext;
    logic               first;
    logic [DECIM_W-1:0] d_cur;
    logic               close;
    logic [ACC_W-1:0]   sum;
    logic [PHASE_W-1:0] rounded;
    logic               in_fire;

    assign i_tready = ~(o_tvalid & ~o_tready);
    assign in_fire  = i_tvalid & i_tready;

    // Modular subtraction gives the natural +/-pi wrap of a binary angle.
    always_comb begin
        diff     = prev_valid ? (i_tdata - prev) : '0;
        diff_ext = {{(ACC_W - PHASE_W){diff[PHASE_W-1]}}, diff};
        first    = (cnt == '0);
        d_cur    = first ? ((decim == '0) ? DECIM_W'(1) : decim) : d_lat;
        close    = i_tlast | (cnt == (d_cur - DECIM_W'(1)));
        sum      = first ? diff_ext : (acc + diff_ext);
    end

    phase_round_sat #(
        .IN_W      (ACC_W),
        .SHIFT_MAX (SHIFT_MAX)
    ) u_round_sat (
        .sum   (sum),
        .shift (shift),
        .sat_c (rounded)
    );

    // A closing sample in the same cycle as an output handshake reloads the slot.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            d_lat      <= DECIM_W'(1);
            o_tvalid   <= 1'b0;
            o_tdata    <= '0;
            o_tlast    <= 1'b0;
        end else if (clear) begin
            prev_valid <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            o_tvalid   <= 1'b0;
        end else begin
            if (o_tready) begin
                o_tvalid <= 1'b0;
            end
            if (in_fire) begin
                prev       <= i_tdata;
                prev_valid <= 1'b1;
                acc        <= sum;
                if (first) begin
                    d_lat <= d_cur;
                end
                if (close) begin
                    cnt      <= '0;
                    o_tvalid <= 1'b1;
                    o_tdata  <= rounded;
                    o_tlast  <= i_tlast;
                end else begin
                    cnt <= cnt + DECIM_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_phase_discriminator_decim.sv
// Directed bench for phase_discriminator_decim with hand-computed expected outputs.
module tb_phase_discriminator_decim;
    import gmrr_phase_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        clear;
    logic [7:0]  decim;
    logic [3:0]  shift;
    logic [15:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [15:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;

    int checks = 0;
    int passed = 0;

    logic [15:0] q_data[$];
    logic        q_last[$];

    phase_discriminator_decim #(.DECIM_W(8), .ACC_W(24)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .clear    (clear),
        .decim    (decim),
        .shift    (shift),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    always #5 aclk = ~aclk;

    // Outputs seen valid+ready on the falling edge complete on the next rising edge.
    always @(negedge aclk) begin
        if (aresetn && o_tvalid && o_tready) begin
            q_data.push_back(o_tdata);
            q_last.push_back(o_tlast);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge aclk);
        #1;
        clear = 1'b0;
        q_data.delete();
        q_last.delete();
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        i_tdata  = d;
        i_tlast  = l;
        i_tvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (i_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL send_timeout: i_tready=%b required 1", i_tready);
        end
        @(posedge aclk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #12;
        checks++; if (o_tvalid !== 1'b0) $display("FAIL rst_o_tvalid: got %b required 0", o_tvalid); else passed++;
        checks++; if (o_tdata !== 16'h0000) $display("FAIL rst_o_tdata: got %h required 0000", o_tdata); else passed++;
        checks++; if (o_tlast !== 1'b0) $display("FAIL rst_o_tlast: got %b required 0", o_tlast); else passed++;
        checks++; if (i_tready !== 1'b1) $display("FAIL rst_i_tready: got %b required 1", i_tready); else passed++;
        @(negedge aclk);
        aresetn = 1'b1;
        wait_cycles(1);
    endtask

    task automatic test_ramp();
        logic [15:0] exp_d[4];
        exp_d[0] = 16'h0000; exp_d[1] = 16'h0100; exp_d[2] = 16'h0100; exp_d[3] = 16'h0100;
        decim = 8'd1; shift = 4'd0;
        do_clear();
        for (int k = 0; k < 4; k++) send(16'(k * 256), 1'b0);
        wait_cycles(3);
        checks++; if (q_data.size() !== 4) $display("FAIL ramp_count: got %0d required 4", q_data.size()); else passed++;
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== exp_d[i] || q_last[i] !== 1'b0)
                $display("FAIL ramp_out%0d: got %h/%b required %h/0", i, q_data[i], q_last[i], exp_d[i]);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        decim = 8'd1; shift = 4'd0;
        do_clear();
        send(ANG_PI - 16'h0100, 1'b0);
        send(ANG_PI + 16'h0100, 1'b0);
        wait_cycles(3);
        checks++; if (q_data.size() !== 2) $display("FAIL wrap_count: got %0d required 2", q_data.size()); else passed++;
        if (q_data.size() >= 2) begin
            checks++; if (q_data[1] !== 16'h0200) $display("FAIL wrap_out: got %h required 0200", q_data[1]); else passed++;
        end
    endtask

    task automatic test_decim_round();
        logic [15:0] exp_d[3];
        exp_d[0] = 16'd2; exp_d[1] = 16'd3; exp_d[2] = 16'd3;
        decim = 8'd4; shift = 4'd2;
        do_clear();
        for (int k = 0; k < 12; k++) send(16'(k * 3), 1'b0);
        wait_cycles(3);
        checks++; if (q_data.size() !== 3) $display("FAIL decim_count: got %0d required 3", q_data.size()); else passed++;
        for (int i = 0; i < 3 && i < q_data.size(); i++) begin
            checks++;
            if (q_data[i] !== exp_d[i]) $display("FAIL decim_out%0d: got %h required %h", i, q_data[i], exp_d[i]);
            else passed++;
        end
    endtask

    task automatic test_shift_clamp();
        decim = 8'd1; shift = 4'd15;
        do_clear();
        send(16'h0000, 1'b0);
        send(16'h7FFF, 1'b0);
        send(16'h0000, 1'b0);
        wait_cycles(3);
        checks++; if (q_data.size() !== 3) $display("FAIL clamp_count: got %0d required 3", q_data.size()); else passed++;
        if (q_data.size() >= 3) begin
            checks++; if (q_data[1] !== 16'h0080) $display("FAIL clamp_pos: got %h required 0080", q_data[1]); else passed++;
            checks++; if (q_data[2] !== 16'hFF80) $display("FAIL clamp_neg: got %h required ff80", q_data[2]); else passed++;
        end
    endtask

    task automatic test_tlast();
        decim = 8'd4; shift = 4'd0;
        do_clear();
        send(16'd0, 1'b0);
        send(16'd5, 1'b1);
        for (int k = 2; k < 6; k++) send(16'(k * 5), 1'b0);
        wait_cycles(3);
        checks++; if (q_data.size() !== 2) $display("FAIL tlast_count: got %0d required 2", q_data.size()); else passed++;
        if (q_data.size() >= 2) begin
            checks++; if (q_data[0] !== 16'd5 || q_last[0] !== 1'b1)
                $display("FAIL tlast_partial: got %h/%b required 0005/1", q_data[0], q_last[0]); else passed++;
            checks++; if (q_data[1] !== 16'd20 || q_last[1] !== 1'b0)
                $display("FAIL tlast_next: got %h/%b required 0014/0", q_data[1], q_last[1]); else passed++;
        end
    endtask

    task automatic test_saturation();
        decim = 8'd255; shift = 4'd0;
        do_clear();
        for (int k = 0; k < 255; k++) send(16'(k * 32'h7000), 1'b0);
        wait_cycles(3);
        checks++; if (q_data.size() !== 1) $display("FAIL sat_pos_count: got %0d required 1", q_data.size()); else passed++;
        if (q_data.size() >= 1) begin
            checks++; if (q_data[0] !== 16'h7FFF) $display("FAIL sat_pos: got %h required 7fff", q_data[0]); else passed++;
        end
        do_clear();
        for (int k = 0; k < 255; k++) send(16'(k * 32'h9000), 1'b0);
        wait_cycles(3);
        checks++; if (q_data.size() !== 1) $display("FAIL sat_neg_count: got %0d required 1", q_data.size()); else passed++;
        if (q_data.size() >= 1) begin
            checks++; if (q_data[0] !== 16'h8000) $display("FAIL sat_neg: got %h required 8000", q_data[0]); else passed++;
        end
    endtask

    task automatic test_backpressure_clear();
        decim = 8'd1; shift = 4'd0; o_tready = 1'b1;
        do_clear();
        send(16'h1000, 1'b0);
        wait_cycles(2);
        o_tready = 1'b0;
        send(16'h1400, 1'b0);
        wait_cycles(2);
        @(negedge aclk);
        checks++; if (o_tvalid !== 1'b1 || o_tdata !== 16'h0400)
            $display("FAIL bp_pending: got %b/%h required 1/0400", o_tvalid, o_tdata); else passed++;
        checks++; if (i_tready !== 1'b0) $display("FAIL bp_ready: got %b required 0", i_tready); else passed++;
        @(posedge aclk); #1;
        i_tdata = 16'h2000; i_tvalid = 1'b1;
        wait_cycles(3);
        @(negedge aclk);
        checks++; if (o_tvalid !== 1'b1 || o_tdata !== 16'h0400)
            $display("FAIL bp_stable: got %b/%h required 1/0400", o_tvalid, o_tdata); else passed++;
        @(posedge aclk); #1;
        i_tvalid = 1'b0;
        do_clear();
        @(negedge aclk);
        checks++; if (o_tvalid !== 1'b0) $display("FAIL clr_valid: got %b required 0", o_tvalid); else passed++;
        checks++; if (i_tready !== 1'b1) $display("FAIL clr_ready: got %b required 1", i_tready); else passed++;
        @(posedge aclk); #1;
        o_tready = 1'b1;
        send(16'h3000, 1'b0);
        wait_cycles(3);
        checks++; if (q_data.size() !== 1) $display("FAIL clr_count: got %0d required 1", q_data.size()); else passed++;
        if (q_data.size() >= 1) begin
            checks++; if (q_data[0] !== 16'h0000) $display("FAIL clr_first_diff: got %h required 0000", q_data[0]); else passed++;
        end
    endtask

    initial begin
        clear = 1'b0; decim = 8'd1; shift = 4'd0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        test_reset();
        test_ramp();
        test_wrap();
        test_decim_round();
        test_shift_clamp();
        test_tlast();
        test_saturation();
        test_backpressure_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
